// File: rtl/backlight_pwm24.sv
// 24-zone backlight PWM stage: captures zone levels at frame end, slew-limits them
// per frame, and applies them only at PWM period boundaries so no pulse is truncated.
module backlight_pwm24 #(
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned CNTW     = 5
) (
  input  logic         iODCK,
  input  logic         iRST,
  input  logic         iV_Duty,
  input  logic [191:0] iBlockData,
  input  logic [7:0]   iStep,
  output logic [23:0]  oPWM,
  output logic [191:0] oLevel,
  output logic         oFrameUpd
);

  typedef enum logic [1:0] {IDLE, SLEW, PEND} state_e;

  state_e         state_q, state_d;
  logic           v_q;
  logic [CNTW-1:0] pre_q, pre_d;
  logic [7:0]     pcnt_q, pcnt_d;
  logic [191:0]   target_q, target_d;
  logic [191:0]   next_q, next_d;
  logic [191:0]   level_q, level_d;
  logic [191:0]   slew_next;
  logic [23:0]    pwm_q, pwm_d;
  logic           upd_q, upd_d;
  logic           frame_edge, tick, wrap;

  // 9-bit differences keep the comparison against iStep free of wraparound.
  function automatic logic [7:0] slew_f(input logic [7:0] t, input logic [7:0] l,
                                        input logic [7:0] s);
    logic [8:0] diff;
    logic [7:0] n;
    n = t;
    if (s != '0) begin
      if (t > l) begin
        diff = {1'b0, t} - {1'b0, l};
        n = (diff > {1'b0, s}) ? l + s : t;
      end else if (t < l) begin
        diff = {1'b0, l} - {1'b0, t};
        n = (diff > {1'b0, s}) ? l - s : t;
      end
    end
    return n;
  endfunction

  assign frame_edge = v_q & ~iV_Duty;
  assign tick       = (pre_q == CNTW'(PRESCALE - 1));
  assign wrap       = tick && (pcnt_q == 8'd254);

  always_comb begin
    pre_d  = tick ? '0 : pre_q + CNTW'(1);
    pcnt_d = pcnt_q;
    if (tick) pcnt_d = (pcnt_q == 8'd254) ? '0 : pcnt_q + 8'd1;
  end

  always_comb begin
    slew_next = '0;
    pwm_d     = '0;
    for (int unsigned k = 0; k < 24; k++) begin
      slew_next[8*k +: 8] = slew_f(target_q[8*k +: 8], level_q[8*k +: 8], iStep);
      pwm_d[k]            = (pcnt_q < level_q[8*k +: 8]);
    end
  end

  // A frame edge overrides everything, including a wrap that would apply a pending update.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    next_d   = next_q;
    level_d  = level_q;
    upd_d    = 1'b0;
    if (frame_edge) begin
      target_d = iBlockData;
      state_d  = SLEW;
    end else begin
      case (state_q)
        IDLE: ;
        SLEW: begin
          next_d  = slew_next;
          state_d = PEND;
        end
        PEND: begin
          if (wrap) begin
            level_d = next_q;
            upd_d   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      state_q  <= IDLE;
      v_q      <= 1'b0;
      pre_q    <= '0;
      pcnt_q   <= '0;
      target_q <= '0;
      next_q   <= '0;
      level_q  <= '0;
      pwm_q    <= '0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      v_q      <= iV_Duty;
      pre_q    <= pre_d;
      pcnt_q   <= pcnt_d;
      target_q <= target_d;
      next_q   <= next_d;
      level_q  <= level_d;
      pwm_q    <= pwm_d;
      upd_q    <= upd_d;
    end
  end

  assign oPWM      = pwm_q;
  assign oLevel    = level_q;
  assign oFrameUpd = upd_q;

endmodule

// File: tb/tb_backlight_pwm24.sv
// Bench for backlight_pwm24: PRESCALE=1 instance checked every cycle against a
// behavioural model, plus a PRESCALE=16 instance checked for pulse width and period.
module tb_backlight_pwm24;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vd, v16;
  logic [191:0] data, d16;
  logic [7:0]   step, s16;
  logic [23:0]  pwm, pwm16;
  logic [191:0] lvl, lvl16;
  logic         upd, upd16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  backlight_pwm24 #(.PRESCALE(1), .CNTW(1)) u_dut (
    .iODCK(clk), .iRST(rst_n), .iV_Duty(vd), .iBlockData(data), .iStep(step),
    .oPWM(pwm), .oLevel(lvl), .oFrameUpd(upd)
  );

  backlight_pwm24 #(.PRESCALE(16), .CNTW(5)) u_dut16 (
    .iODCK(clk), .iRST(rst_n), .iV_Duty(v16), .iBlockData(d16), .iStep(s16),
    .oPWM(pwm16), .oLevel(lvl16), .oFrameUpd(upd16)
  );

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model of the PRESCALE=1 instance ----------------
  localparam int MP = 1;
  longint     cyc;
  bit         m_v, m_slew, m_pend, m_upd;
  logic [23:0] m_pwm;
  int         m_tgt[24], m_nxt[24], m_lvl[24];

  function automatic int slew_ref(int t, int l, int s);
    if (s == 0 || t == l) return t;
    if (t > l) return (l + s < t) ? l + s : t;
    return (l - s > t) ? l - s : t;
  endfunction

  function automatic logic [191:0] model_levels();
    logic [191:0] v = '0;
    for (int k = 0; k < 24; k++) v[8*k +: 8] = 8'(m_lvl[k]);
    return v;
  endfunction

  always @(posedge clk) begin : model
    int  pcnt;
    bit  wrap;
    if (!rst_n) begin
      cyc = 0; m_v = 0; m_slew = 0; m_pend = 0; m_upd = 0; m_pwm = '0;
      for (int k = 0; k < 24; k++) begin m_tgt[k] = 0; m_nxt[k] = 0; m_lvl[k] = 0; end
    end else begin
      pcnt = int'((cyc / MP) % 255);
      wrap = ((cyc % MP) == MP - 1) && (pcnt == 254);
      for (int k = 0; k < 24; k++) m_pwm[k] = (pcnt < m_lvl[k]);
      m_upd = 0;
      if (m_v && !vd) begin
        for (int k = 0; k < 24; k++) m_tgt[k] = int'(data[8*k +: 8]);
        m_slew = 1; m_pend = 0;
      end else if (m_slew) begin
        for (int k = 0; k < 24; k++) m_nxt[k] = slew_ref(m_tgt[k], m_lvl[k], int'(step));
        m_slew = 0; m_pend = 1;
      end else if (m_pend && wrap) begin
        for (int k = 0; k < 24; k++) m_lvl[k] = m_nxt[k];
        m_upd = 1; m_pend = 0;
      end
      m_v = vd;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("model_level", lvl, model_levels());
      chk("model_upd", upd, m_upd);
      chk("model_pwm", pwm, m_pwm);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic frame_edge(input logic [191:0] d, input logic [7:0] s);
    data = d; step = s; vd = 1'b1;
    @(negedge clk);
    vd = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_upd(input bit sel16, input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((sel16 ? upd16 : upd) !== 1'b1) && n < limit);
    if (sel16) chk("upd16_wait", upd16, 1'b1);
    else       chk("upd_wait", upd, 1'b1);
  endtask

  logic [191:0] base, dv;
  logic [7:0]   up_exp[5]   = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h40};
  logic [7:0]   down_exp[4] = '{8'h30, 8'h20, 8'h10, 8'h08};
  int c0, c23, coth, npulse, len, per;
  bit saw20, prev;

  initial begin
    rst_n = 1'b0; vd = 1'b0; data = '0; step = '0;
    v16 = 1'b0; d16 = '0; s16 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pwm", pwm, '0);   chk("rst_level", lvl, '0);     chk("rst_upd", upd, '0);
    chk("rst_pwm16", pwm16, '0); chk("rst_level16", lvl16, '0); chk("rst_upd16", upd16, '0);

    // Direct update with no slew limiting
    base = '0; base[7:0] = 8'h80; base[191:184] = 8'hFF;
    frame_edge(base, 8'd0);
    wait_upd(1'b0, 600);
    chk("direct_level", lvl, base);
    c0 = 0; c23 = 0; coth = 0;
    repeat (255) begin
      @(negedge clk);
      c0 += int'(pwm[0]); c23 += int'(pwm[23]); coth += int'(|pwm[22:1]);
    end
    chk("direct_duty0", 192'(c0), 192'(128));
    chk("direct_duty23", 192'(c23), 192'(255));
    chk("direct_others", 192'(coth), 192'(0));

    // Slew up, then down, step 16 on zone 5
    dv = base; dv[47:40] = 8'h40;
    for (int i = 0; i < 5; i++) begin
      frame_edge(dv, 8'd16);
      wait_upd(1'b0, 600);
      chk("slew_up", lvl[47:40], up_exp[i]);
    end
    dv[47:40] = 8'h08;
    for (int i = 0; i < 4; i++) begin
      frame_edge(dv, 8'd16);
      wait_upd(1'b0, 600);
      chk("slew_down", lvl[47:40], down_exp[i]);
    end

    // Back-to-back edges before one wrap: only the second target lands
    dv[47:40] = 8'h20;
    frame_edge(dv, 8'd0);
    dv[47:40] = 8'h90;
    frame_edge(dv, 8'd0);
    npulse = 0; saw20 = 0;
    repeat (600) begin
      @(negedge clk);
      npulse += int'(upd);
      if (lvl[47:40] == 8'h20) saw20 = 1;
    end
    chk("b2b_pulses", 192'(npulse), 192'(1));
    chk("b2b_level", lvl[47:40], 8'h90);
    chk("b2b_no_first", 192'(saw20), 192'(0));

    // Frame edge landing exactly on a wrap while pending
    dv[47:40] = 8'h55;
    frame_edge(dv, 8'd0);
    wait_upd(1'b0, 600);
    dv[47:40] = 8'h33; data = dv; vd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vd = 1'b0;
    @(negedge clk);
    vd = 1'b1; dv[47:40] = 8'h66; data = dv;
    repeat (251) @(negedge clk);
    vd = 1'b0;
    @(negedge clk);
    chk("coinc_upd", upd, 1'b0);
    chk("coinc_level", lvl[47:40], 8'h55);
    wait_upd(1'b0, 600);
    chk("coinc_applied", lvl[47:40], 8'h66);

    // Asynchronous reset in the middle of a pending update
    frame_edge(base, 8'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pwm", pwm, '0); chk("arst_level", lvl, '0); chk("arst_upd", upd, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    repeat (600) begin
      @(negedge clk);
      npulse += int'(upd);
    end
    chk("arst_no_upd", 192'(npulse), 192'(0));

    // Randomized frames checked by the model
    for (int i = 0; i < 20; i++) begin
      for (int w = 0; w < 6; w++) dv[32*w +: 32] = $urandom;
      frame_edge(dv, ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
      repeat ($urandom_range(0, 400)) @(negedge clk);
    end

    // PRESCALE=16: level 1 gives a 16-clock pulse every 4080 clocks
    d16 = '0; d16[7:0] = 8'h01; d16[15:8] = 8'hFF; s16 = 8'd0;
    v16 = 1'b1; @(negedge clk); v16 = 1'b0;
    wait_upd(1'b1, 8300);
    chk("p16_level", lvl16[15:0], 16'hFF01);
    d16[7:0] = 8'h02; v16 = 1'b1;
    len = 0;
    while (pwm16[0] !== 1'b1 && len < 4200) begin @(negedge clk); len++; end
    chk("p16_rise", pwm16[0], 1'b1);
    v16 = 1'b0;                       // update issued mid-pulse
    len = 1; per = 1; npulse = 0; prev = 1'b1;
    forever begin
      @(negedge clk);
      npulse += int'(upd16);
      if (pwm16[0] && !prev) break;
      if (pwm16[0]) len++;
      prev = pwm16[0];
      per++;
      if (per > 5000) break;
    end
    chk("p16_width_old", 192'(len), 192'(16));
    chk("p16_period", 192'(per), 192'(4080));
    chk("p16_pulses", 192'(npulse), 192'(1));
    len = 1;
    while (len < 100) begin
      @(negedge clk);
      if (!pwm16[0]) break;
      len++;
    end
    chk("p16_width_new", 192'(len), 192'(32));
    chk("p16_always_hi", pwm16[1], 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/backlight_pwm24.md
# backlight_pwm24

Downstream stage of the 24-zone dynamic-backlight dimming datapath. Captures the 24 per-zone 8-bit backlight levels produced by the zone analysis array at each frame end, applies per-frame slew limiting to suppress flicker, and drives 24 glitch-free PWM outputs to the LED backlight drivers. New levels are applied only at a PWM period boundary, so no output pulse is ever truncated.

## Interface
- PRESCALE, 16: system clocks per PWM tick (≥1).
- CNTW, 5: prescaler counter width; must satisfy 2^CNTW ≥ PRESCALE.
- iODCK  in  1  pixel/system clock; all logic on the rising edge.
- iRST  in  1  reset, asynchronous, active-low.
- iV_Duty  in  1  vertical active window; the falling edge marks frame end.
- iBlockData  in  192  24 zone levels; zone k at [8k+7:8k].
- iStep  in  8  max level change per frame per zone; 0 = no limiting.
- oPWM  out  24  PWM outputs; bit k for zone k.
- oLevel  out  192  currently applied levels, same packing as iBlockData.
- oFrameUpd  out  1  one-cycle pulse after new levels are applied.

## Operation
- Frame edge: register v_d <= iV_Duty each clock. The edge is the clock where v_d=1 and iV_Duty=0.
- Prescaler: pre counts 0..PRESCALE-1 and wraps. tick=1 when pre==PRESCALE-1.
- PWM counter: pcnt 0..254 advances on tick; 254 wraps to 0. PWM period = 255 ticks.
- wrap = tick && pcnt==254.
- oPWM[k] is registered: (pcnt < level[k]).
  - Level 0: output constantly low.
  - Level 255: output constantly high.
  - Level L: high for L ticks per period, starting at pcnt=0.
- FSM states: IDLE, SLEW, PEND.
  - Any state, frame edge: target <= iBlockData; go to SLEW. Any pending update is discarded.
  - SLEW: per zone, compute next from target and level as below; go to PEND.
    - iStep==0: next = target.
    - target>level: next = min(target, level+iStep).
    - target<level: next = max(target, level−iStep).
    - Use 9-bit differences. Results never overflow or underflow 0..255.
  - PEND, on wrap: level <= next; oFrameUpd <= 1 for the next cycle; go to IDLE. Otherwise stay.
  - A wrap in the same cycle as SLEW is not used; PEND waits for the following wrap.
- Frame edge and wrap in the same cycle while in PEND: the edge wins. Target is recaptured, state goes to SLEW, level is unchanged, no pulse.
- Slew state is per frame: level converges on target over successive frames, one iStep per frame.

## Timing
- Reset (asynchronous, immediate):
  - oPWM=0, oLevel=0, oFrameUpd=0.
  - target, next, pre, pcnt, v_d all 0; state IDLE.
- Frame edge at clock edge T:
  - target captured at T.
  - next registered at T+1.
  - level updated at the first wrap edge ≥ T+2; oLevel changes on that same edge.
  - oFrameUpd high for exactly one cycle following that edge.
- oPWM lags pcnt/level by one clock. The new duty takes effect from the start of the period beginning with pcnt=0.
- Worst-case latency, frame edge to applied: 2 + 255·PRESCALE clocks.
- Reset released while iV_Duty=1: the first falling edge is a valid frame edge.
- Reset released while iV_Duty=0: no edge until iV_Duty rises and falls again.

## Test plan
- Reset: assert iRST=0 mid-PEND with nonzero levels → all outputs are 0 at once. After release, no oFrameUpd until a new frame edge.
- Direct update, PRESCALE=1, iStep=0, zone0=0x80, zone23=0xFF, others 0, one frame edge:
  - oLevel updated at the next wrap with one oFrameUpd pulse.
  - oPWM[0] is high 128 of every 255 clocks.
  - oPWM[23] is constantly high; others constantly low.
- Slew up/down, iStep=16:
  - From level 0, target zone5=0x40 held over frames → applied 0x10, 0x20, 0x30, 0x40, then unchanged.
  - Then target 0x08 → 0x30, 0x20, 0x10, 0x08.
- Back-to-back frame edges before a wrap, targets 0x20 then 0x90 (iStep=0) → a single application of 0x90 and a single oFrameUpd pulse.
- Prescale, PRESCALE=16, level 0x01 → oPWM high for 16 clocks every 4080 clocks. An update issued mid-period never shortens or splits a pulse.
- Edge coincident with wrap in PEND → no update or pulse that cycle. The new target is applied at the following wrap.
